// File: rtl/mult_unit_pkg.sv
// ============================================================================
//  Module      : mult_unit_pkg
//  Description : Shared CPU encodings: ALU operation codes, data width and
//                multiplier FSM states.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mult_unit_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ALUOP_FWD = 3'b000,
        ALUOP_ADD = 3'b001,
        ALUOP_AND = 3'b010,
        ALUOP_OR  = 3'b011,
        ALUOP_MUL = 3'b100
    } aluop_t;

    typedef enum logic [1:0] {
        MUL_IDLE   = 2'd0,
        MUL_RUN    = 2'd1,
        MUL_FINISH = 2'd2
    } mult_state_t;

endpackage

`default_nettype wire

// File: rtl/mult_step.sv
// ============================================================================
//  Module      : mult_step
//  Description : One combinational radix-2 Booth step: add/subtract the
//                multiplicand, then arithmetic-shift {acc, mplier, qm1} right.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mult_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_mplier,
    input  logic             i_qm1,
    input  logic [WIDTH-1:0] i_mcand,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_mplier,
    output logic             o_qm1
);

    // One guard bit on the accumulator keeps +/- of the most negative operand exact.
    logic [WIDTH:0] w_mcand_ext;
    logic [WIDTH:0] w_sum;

    assign w_mcand_ext = {i_mcand[WIDTH-1], i_mcand};

    always_comb begin
        w_sum = i_acc;
        case ({i_mplier[0], i_qm1})
            2'b01:   w_sum = i_acc + w_mcand_ext;
            2'b10:   w_sum = i_acc - w_mcand_ext;
            default: w_sum = i_acc;
        endcase
    end

    assign o_acc    = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_mplier = {w_sum[0], i_mplier[WIDTH-1:1]};
    assign o_qm1    = i_mplier[0];

endmodule

`default_nettype wire

// File: rtl/mult_unit.sv
// ============================================================================
//  Module      : mult_unit
//  Description : Sequential signed WIDTHxWIDTH multiplier with pipeline stall
//                and one-cycle DONE pulse.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mult_unit
    import mult_unit_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [2:0]         ALUOP,
    input  logic               START,
    input  logic [WIDTH-1:0]   DATA1,
    input  logic [WIDTH-1:0]   DATA2,
    output logic [WIDTH-1:0]   RESULT,
    output logic [2*WIDTH-1:0] PRODUCT,
    output logic               OVERFLOW,
    output logic               BUSY,
    output logic               DONE,
    output logic               STALL
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH);

    mult_state_t        r_state;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_qm1;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;
    logic               r_overflow;

    logic               w_cmd;
    logic [WIDTH:0]     w_acc_next;
    logic [WIDTH-1:0]   w_mplier_next;
    logic               w_qm1_next;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_ovf;

    assign w_cmd  = START && (ALUOP == ALUOP_MUL);
    assign w_prod = {r_acc[WIDTH-1:0], r_mplier};
    // Representable in WIDTH signed bits only if the top WIDTH+1 bits are a pure sign run.
    assign w_ovf  = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));

    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc    (r_acc),
        .i_mplier (r_mplier),
        .i_qm1    (r_qm1),
        .i_mcand  (r_mcand),
        .o_acc    (w_acc_next),
        .o_mplier (w_mplier_next),
        .o_qm1    (w_qm1_next)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state    <= MUL_IDLE;
            r_count    <= '0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_mplier   <= '0;
            r_qm1      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_product  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MUL_IDLE: begin
                    if (w_cmd) begin
                        r_mcand  <= DATA1;
                        r_mplier <= DATA2;
                        r_acc    <= '0;
                        r_qm1    <= 1'b0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    // WIDTH Booth steps, then one edge to publish the product.
                    if (r_count == c_last) begin
                        r_product  <= w_prod;
                        r_overflow <= w_ovf;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= MUL_FINISH;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mplier <= w_mplier_next;
                        r_qm1    <= w_qm1_next;
                        r_count  <= r_count + CNT_W'(1);
                    end
                end
                MUL_FINISH: r_state <= MUL_IDLE;
                default:    r_state <= MUL_IDLE;
            endcase
        end
    end

    assign RESULT   = r_product[WIDTH-1:0];
    assign PRODUCT  = r_product;
    assign OVERFLOW = r_overflow;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign STALL    = ((r_state == MUL_IDLE) && w_cmd) || ((r_state == MUL_RUN) && RESET);

endmodule

`default_nettype wire

// File: tb/tb_mult_unit.sv
// ============================================================================
//  Module      : tb_mult_unit
//  Description : Self-checking bench for mult_unit (vector table + scoreboard).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mult_unit;
    import mult_unit_pkg::*;

    localparam int W = 8;

    logic           CLK = 1'b0;
    logic           RESET = 1'b0;
    logic [2:0]     ALUOP = 3'b000;
    logic           START = 1'b0;
    logic [W-1:0]   DATA1 = '0;
    logic [W-1:0]   DATA2 = '0;
    logic [W-1:0]   RESULT;
    logic [2*W-1:0] PRODUCT;
    logic           OVERFLOW;
    logic           BUSY;
    logic           DONE;
    logic           STALL;

    mult_unit #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ALUOP    (ALUOP),
        .START    (START),
        .DATA1    (DATA1),
        .DATA2    (DATA2),
        .RESULT   (RESULT),
        .PRODUCT  (PRODUCT),
        .OVERFLOW (OVERFLOW),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .STALL    (STALL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        logic           ov;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[10];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        logic signed [2*W-1:0] p;
        p    = $signed(a) * $signed(b);
        v.a  = a;
        v.b  = b;
        v.p  = p;
        v.ov = (p > 127) || (p < -128);
        return v;
    endfunction

    task automatic compare_out(input vec_t e, input string tag);
        check({tag, "_product"}, PRODUCT, e.p);
        check({tag, "_result"}, RESULT, e.p[W-1:0]);
        check({tag, "_overflow"}, OVERFLOW, e.ov);
    endtask

    // Issue one multiply, follow it to DONE and score against the queue head.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t e;
        int   n;
        DATA1 = a; DATA2 = b; ALUOP = ALUOP_MUL; START = 1'b1;
        #1;
        check("stall_on_start", STALL, 1);
        tick();
        START = 1'b0; ALUOP = ALUOP_FWD; DATA1 = ~a; DATA2 = ~b;
        n = 0;
        while (n < 3 * W) begin
            if (DONE) break;
            check("stall_run", STALL, 1);
            check("busy_run", BUSY, 1);
            tick();
            n++;
        end
        check("latency", n, W + 1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            compare_out(e, "op");
            check("busy_finish", BUSY, 0);
            check("stall_finish", STALL, 0);
            tick();
            check("done_pulse", DONE, 0);
            check("hold_product", PRODUCT, e.p);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        int   n;
        int   dones;
        int   first;

        tbl[0] = '{8'h05, 8'h03, 16'h000F, 1'b0};
        tbl[1] = '{8'hFC, 8'h07, 16'hFFE4, 1'b0};
        tbl[2] = '{8'h10, 8'h10, 16'h0100, 1'b1};
        tbl[3] = '{8'h80, 8'hFF, 16'h0080, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 16'h4000, 1'b1};
        tbl[5] = '{8'h7F, 8'h7F, 16'h3F01, 1'b1};
        tbl[6] = '{8'hFF, 8'hFF, 16'h0001, 1'b0};
        tbl[7] = '{8'h00, 8'h5A, 16'h0000, 1'b0};
        tbl[8] = '{8'h80, 8'h01, 16'hFF80, 1'b0};
        tbl[9] = '{8'hF6, 8'h0C, 16'hFF88, 1'b0};

        // Reset state, then reset priority over a multiply command.
        RESET = 1'b0;
        tick(); tick();
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_product", PRODUCT, 0);
        check("rst_result", RESULT, 0);
        check("rst_overflow", OVERFLOW, 0);
        check("rst_stall", STALL, 0);
        DATA1 = 8'h05; DATA2 = 8'h05; ALUOP = ALUOP_MUL; START = 1'b1;
        #1;
        check("rst_stall_cmd", STALL, 1);
        tick();
        START = 1'b0;
        check("rst_priority_busy", BUSY, 0);
        RESET = 1'b1;
        tick();

        foreach (tbl[i]) begin
            exp_q.push_back(tbl[i]);
            run_op(tbl[i].a, tbl[i].b);
        end

        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            exp_q.push_back(model(a, b));
            run_op(a, b);
        end

        // Non-multiply START is ignored; last result (0xF6*0x0C... then random) held.
        e = model(8'h21, 8'h03);
        exp_q.push_back(e);
        run_op(8'h21, 8'h03);
        DATA1 = 8'h11; DATA2 = 8'h22; ALUOP = ALUOP_ADD; START = 1'b1;
        #1;
        check("aluop_add_stall", STALL, 0);
        tick();
        START = 1'b0;
        check("aluop_add_busy", BUSY, 0);
        check("aluop_add_done", DONE, 0);
        check("aluop_add_hold", PRODUCT, e.p);

        // A second command at RUN edge 3 is dropped; exactly one DONE for 6*7.
        exp_q.push_back('{8'h06, 8'h07, 16'h002A, 1'b0});
        DATA1 = 8'h06; DATA2 = 8'h07; ALUOP = ALUOP_MUL; START = 1'b1;
        tick();
        START = 1'b0;
        dones = 0; first = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                DATA1 = 8'h09; DATA2 = 8'h09; ALUOP = ALUOP_MUL; START = 1'b1;
            end else if (k == 4) begin
                START = 1'b0;
            end
            tick();
            if (DONE) begin
                dones++;
                if (first < 0) begin
                    first = k;
                    e = exp_q.pop_front();
                    compare_out(e, "busy_start");
                end
            end
        end
        check("busy_start_dones", dones, 1);
        check("busy_start_latency", first, W + 1);

        // Reset asserted before RUN edge 4 aborts without DONE.
        DATA1 = 8'h33; DATA2 = 8'h02; ALUOP = ALUOP_MUL; START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick(); tick();
        RESET = 1'b0;
        #1;
        check("rst_run_stall", STALL, 0);
        tick();
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_product", PRODUCT, 0);
        check("abort_result", RESULT, 0);
        check("abort_overflow", OVERFLOW, 0);
        check("abort_stall", STALL, 0);
        RESET = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (DONE) dones++;
        end
        check("abort_no_done", dones, 0);
        exp_q.push_back(model(8'h02, 8'h03));
        run_op(8'h02, 8'h03);

        // START held through FINISH is only taken on the following IDLE cycle.
        DATA1 = 8'h7F; DATA2 = 8'h02; ALUOP = ALUOP_MUL; START = 1'b1;
        tick();
        START = 1'b0;
        n = 0;
        while (!DONE && n < 3 * W) begin
            tick();
            n++;
        end
        check("fin_first_latency", n, W + 1);
        compare_out('{8'h7F, 8'h02, 16'h00FE, 1'b1}, "fin_first");
        DATA1 = 8'h03; DATA2 = 8'h04; START = 1'b1;
        #1;
        check("fin_stall", STALL, 0);
        tick();
        check("fin_not_accepted", BUSY, 0);
        check("idle_stall", STALL, 1);
        tick();
        START = 1'b0;
        n = 0;
        while (!DONE && n < 3 * W) begin
            tick();
            n++;
        end
        check("fin_second_latency", n, W + 1);
        compare_out('{8'h03, 8'h04, 16'h000C, 1'b0}, "fin_second");

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 The block SHALL have this parameter: WIDTH, default 8, operand and register width in bits.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: reset, synchronous, active-low; the block is in reset when RESET=0 at a rising CLK edge.
REQ-004 The block SHALL have port ALUOP, input, 3 bits: operation select from the control unit; 3'b100 = multiply.
REQ-005 The block SHALL have port START, input, 1 bit: command strobe, sampled every edge.
REQ-006 The block SHALL have port DATA1, input, WIDTH bits: multiplicand, two's complement.
REQ-007 The block SHALL have port DATA2, input, WIDTH bits: multiplier, two's complement.
REQ-008 The block SHALL have port RESULT, output, WIDTH bits: low WIDTH bits of the product, for register writeback.
REQ-009 The block SHALL have port PRODUCT, output, 2*WIDTH bits: full signed product.
REQ-010 The block SHALL have port OVERFLOW, output, 1 bit: the product is not representable in WIDTH signed bits.
REQ-011 The block SHALL have port BUSY, output, 1 bit: registered; high while the multiply is in progress.
REQ-012 The block SHALL have port DONE, output, 1 bit: registered one-cycle pulse; RESULT, PRODUCT and OVERFLOW are valid.
REQ-013 The block SHALL have port STALL, output, 1 bit: combinational; holds the PC and register write until DONE.

Function
REQ-014 The block SHALL have three states: IDLE, RUN and FINISH.
REQ-015 A command SHALL be accepted only in IDLE, at an edge where START=1 and ALUOP=3'b100.
REQ-016 On acceptance the block SHALL capture DATA1 and DATA2, clear the accumulator, set the bit counter to 0, set BUSY=1 and enter RUN.
REQ-017 In IDLE, START with any other ALUOP SHALL be ignored.
REQ-018 Each RUN edge SHALL process one multiplier bit with a shift-add step, in radix-2 Booth or an equivalent signed method.
REQ-019 After the WIDTH-th RUN edge the block SHALL enter FINISH, set BUSY=0 and DONE=1.
REQ-020 Latency: DONE SHALL be high during the cycle that starts WIDTH+1 edges after the accepting edge (9 edges for WIDTH=8).
REQ-021 FINISH SHALL last exactly one cycle and then return to IDLE; DONE SHALL drop with it.
REQ-022 PRODUCT SHALL equal signed(DATA1) times signed(DATA2), exact, 2*WIDTH bits.
REQ-023 RESULT SHALL be PRODUCT[WIDTH-1:0].
REQ-024 OVERFLOW SHALL be 1 exactly when PRODUCT[2*WIDTH-1:WIDTH-1] is not all equal bits.
REQ-025 RESULT, PRODUCT and OVERFLOW SHALL hold their values from FINISH until the next acceptance; they are undefined-free and stable in IDLE.
REQ-026 START during RUN or FINISH SHALL be ignored, with no queuing; DATA1 and DATA2 changes during RUN SHALL not affect the result.
REQ-027 STALL SHALL be (state==IDLE & START & ALUOP==3'b100) | (state==RUN).
REQ-028 STALL SHALL be 0 in FINISH, so that writeback and PC advance occur on the DONE cycle.
REQ-029 START accepted on the edge that leaves FINISH SHALL not occur; the earliest new acceptance is the first IDLE cycle.

Reset
REQ-030 When RESET=0 at an edge, the block SHALL set state=IDLE, BUSY=0, DONE=0, RESULT=0, PRODUCT=0, OVERFLOW=0 and counter=0.
REQ-031 Reset SHALL have priority over START.
REQ-032 Reset mid-RUN SHALL abort the operation with no DONE pulse.
REQ-033 STALL SHALL be 0 while in reset unless START with multiply is presented.

Structure
REQ-034 The shared CPU package SHALL hold the ALUOP encodings (ALUOP_FWD=000, ALUOP_ADD=001, ALUOP_AND=010, ALUOP_OR=011, ALUOP_MUL=100), the data WIDTH constant and the mult_unit state encoding.
REQ-035 One sub-module, mult_step, SHALL implement the combinational single Booth add/sub-and-shift step; mult_unit instantiates it once and owns the FSM, counter and registers.

Verification
REQ-036 Scenario 1: DATA1=5, DATA2=3, ALUOP=100, START pulse -> DONE 9 edges later, RESULT=0x0F, PRODUCT=0x000F, OVERFLOW=0; STALL high for 9 cycles.
REQ-037 Scenario 2: DATA1=0xFC (-4), DATA2=7 -> RESULT=0xE4, PRODUCT=0xFFE4, OVERFLOW=0.
REQ-038 Scenario 3: DATA1=16, DATA2=16 -> PRODUCT=0x0100, RESULT=0x00, OVERFLOW=1; DATA1=0x80, DATA2=0xFF -> PRODUCT=0x0080, RESULT=0x80, OVERFLOW=1.
REQ-039 Scenario 4: START with ALUOP=001 -> BUSY, STALL and DONE stay 0 and outputs unchanged; second START with ALUOP=100 at RUN edge 3 (operands 9, 9) -> ignored, first result delivered, single DONE.
REQ-040 Scenario 5: RESET=0 at RUN edge 4 -> next cycle IDLE, all outputs 0, no DONE; new 2*3 afterwards -> RESULT=0x06 with full latency.
